// File: rtl/conv_mac_acc.sv
// conv_mac_acc: parametrised KERNEL x KERNEL convolution MAC with cross-channel
// accumulation. Each accepted beat multiplies a packed window by a packed kernel
// tap by tap. The products are reduced by a registered adder tree and
// accumulated over IN_CHANNELS beats. The group total is then scaled back to the
// Q format, saturated, optionally clamped by ReLU and emitted as one pixel.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     beat qualifier (no backpressure, gaps allowed)
//   in_data      N packed signed taps, tap i at [i*DATA_WIDTH +: DATA_WIDTH]
//   weight_data  N packed signed weights, same packing
//   bias         signed Q-format bias, used on a group's first beat only
//   out_valid    one-cycle pulse per completed group
//   out_data     saturated result, held until the next out_valid

// One tap: registered full-precision signed product, sign-extended to ACC_W.
module conv_mac_tap #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 41
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] w,
  output logic [ACC_W-1:0]      p
);
  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] a_x, w_x, prod;

  // Operands sign-extended to the product width, so the low PW bits of the
  // product are the exact signed result.
  assign a_x  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign w_x  = {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w};
  assign prod = a_x * w_x;

  always_ff @(posedge clk) p <= {{(ACC_W-PW){prod[PW-1]}}, prod};
endmodule

module conv_mac_acc #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int KERNEL      = 5,
  parameter int IN_CHANNELS = 6,
  parameter int RELU_EN     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0] in_data,
  input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0] weight_data,
  input  logic [DATA_WIDTH-1:0]               bias,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data
);
  localparam int N      = KERNEL * KERNEL;
  localparam int T      = $clog2(N + 1);
  localparam int ACC_W  = 2*DATA_WIDTH + $clog2(N*IN_CHANNELS + 1) + 1;
  localparam int CW     = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int STAGES = T + 2;  // M, T tree levels, accumulate

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Node count of tree level l; level 0 is the N products plus the bias leaf.
  function automatic int lvl_cnt(input int l);
    int c;
    c = N + 1;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

  logic                 take, first_in, last_in;
  logic [CW-1:0]        ch_cnt;
  logic [ACC_W-1:0]     bias_leaf, tree_sum;
  logic [STAGES:1]      vld_pipe, last_pipe;
  logic [STAGES-1:1]    first_pipe;
  logic signed [ACC_W-1:0] acc, shifted;
  logic [DATA_WIDTH-1:0] res;

  assign take      = in_valid & ~rst;
  assign first_in  = (ch_cnt == '0);
  assign last_in   = (ch_cnt == CW'(IN_CHANNELS - 1));
  assign bias_leaf = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} << FRAC_BITS;

  always_ff @(posedge clk) begin
    if (rst)       ch_cnt <= '0;
    else if (take) ch_cnt <= last_in ? '0 : ch_cnt + 1'b1;
  end

  // Valid and group tags ride alongside the data through M, tree and acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], take};
      first_pipe <= {first_pipe[STAGES-2:1], first_in};
      last_pipe  <= {last_pipe[STAGES-1:1], last_in};
    end
  end

  // Level 0 is the product/bias register stage; levels 1..T add pairwise, an
  // unpaired node is carried through a register so all paths stay aligned.
  for (genvar l = 0; l <= T; l++) begin : g_lvl
    localparam int NO = lvl_cnt(l);
    logic [ACC_W-1:0] node [NO];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_tap
        conv_mac_tap #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_tap (
          .clk (clk),
          .a   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
          .w   (weight_data[i*DATA_WIDTH +: DATA_WIDTH]),
          .p   (node[i])
        );
      end
      always_ff @(posedge clk) node[N] <= first_in ? bias_leaf : '0;
    end else begin : g_add
      localparam int NI = lvl_cnt(l - 1);
      for (genvar j = 0; j < NO; j++) begin : g_node
        if (2*j + 1 < NI) begin : g_pair
          always_ff @(posedge clk)
            node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
        end else begin : g_pass
          always_ff @(posedge clk) node[j] <= g_lvl[l-1].node[2*j];
        end
      end
    end
  end

  assign tree_sum = g_lvl[T].node[0];

  // The first tag reloads acc, so a new group never inherits the old total.
  always_ff @(posedge clk) begin
    if (rst)                 acc <= '0;
    else if (vld_pipe[T+1])  acc <= first_pipe[T+1] ? tree_sum : acc + tree_sum;
  end

  assign shifted = acc >>> FRAC_BITS;  // floor toward -inf

  always_comb begin
    res = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
    if (RELU_EN != 0 && res[DATA_WIDTH-1]) res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= vld_pipe[STAGES] & last_pipe[STAGES];
      if (vld_pipe[STAGES] & last_pipe[STAGES]) out_data <= res;
    end
  end
endmodule

// File: tb/tb_conv_mac_acc.sv
// Bench for conv_mac_acc. Three instances share one stimulus stream:
//   0: defaults (IN_CHANNELS=6, ReLU on)
//   1: IN_CHANNELS=1, ReLU off
//   2: IN_CHANNELS=1, ReLU on
// An arithmetic reference model predicts every pixel and the edge it appears on.
module tb_conv_mac_acc;
  localparam int N   = 25;
  localparam int DW  = 16;
  localparam int LAT = 7;  // edges from the accepting edge to the out_valid edge

  logic clk = 0;
  logic rst, in_valid;
  logic [N-1:0][DW-1:0] din, wdat;
  logic [DW-1:0] bias_v;
  logic          ov [3];
  logic [DW-1:0] od [3];

  always #5 clk = ~clk;

  conv_mac_acc dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(din), .weight_data(wdat),
    .bias(bias_v), .out_valid(ov[0]), .out_data(od[0]));
  conv_mac_acc #(.IN_CHANNELS(1), .RELU_EN(0)) dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(din), .weight_data(wdat),
    .bias(bias_v), .out_valid(ov[1]), .out_data(od[1]));
  conv_mac_acc #(.IN_CHANNELS(1), .RELU_EN(1)) dut_1r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(din), .weight_data(wdat),
    .bias(bias_v), .out_valid(ov[2]), .out_data(od[2]));

  typedef struct { int dut; int due; logic [DW-1:0] val; } exp_t;
  exp_t q[$];
  int     checks = 0, errors = 0, edge_n = 0;
  int     cnt [3];
  longint acc [3];
  logic [DW-1:0] held [3];
  int     ic   [3] = '{6, 1, 1};
  int     relu [3] = '{1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: group sum in plain 64-bit arithmetic, then floor/saturate/ReLU.
  task automatic model_beat();
    longint s, r;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      s = 0;
      for (int i = 0; i < N; i++)
        s += longint'($signed(din[i])) * longint'($signed(wdat[i]));
      if (cnt[d] == 0) s += longint'($signed(bias_v)) * 256;
      acc[d] = (cnt[d] == 0) ? s : acc[d] + s;
      if (cnt[d] == ic[d] - 1) begin
        r = acc[d] >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu[d] != 0 && r < 0) r = 0;
        e.dut = d; e.due = edge_n + LAT; e.val = r[DW-1:0];
        q.push_back(e);
        cnt[d] = 0;
      end else cnt[d]++;
    end
  endtask

  // One clock: update the model at the edge, then check all outputs 1 time unit later.
  task automatic tick();
    logic ev;
    logic [DW-1:0] ed;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete();
      for (int d = 0; d < 3; d++) begin cnt[d] = 0; acc[d] = 0; held[d] = '0; end
    end else if (in_valid) model_beat();
    #1;
    for (int d = 0; d < 3; d++) begin
      ev = 1'b0; ed = '0;
      foreach (q[k]) if (q[k].dut == d && q[k].due == edge_n) begin ev = 1'b1; ed = q[k].val; end
      if (ev) held[d] = ed;
      chk($sformatf("out_valid%0d@%0d", d, edge_n), {31'b0, ov[d]}, {31'b0, ev});
      chk($sformatf("out_data%0d@%0d", d, edge_n), {16'b0, od[d]}, {16'b0, held[d]});
    end
    while (q.size() > 0 && q[0].due <= edge_n) void'(q.pop_front());
  endtask

  task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] w,
                      input logic [DW-1:0] a0, input logic [DW-1:0] w0);
    for (int i = 0; i < N; i++) begin din[i] = a; wdat[i] = w; end
    din[0] = a0; wdat[0] = w0;
  endtask

  task automatic beat();
    in_valid = 1'b1; tick(); in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic rand_window();
    for (int i = 0; i < N; i++) begin
      din[i]  = DW'($urandom);
      wdat[i] = DW'($urandom);
    end
    bias_v = DW'($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; bias_v = '0;
    fill(16'd0, 16'd0, 16'd0, 16'd0);
    for (int d = 0; d < 3; d++) begin cnt[d] = 0; acc[d] = 0; held[d] = '0; end
    do_reset(2);

    // All taps 1.0 x 1.0, no bias: 25.0 on the single-channel instance.
    fill(16'd256, 16'd256, 16'd256, 16'd256);
    beat(); idle(9);
    chk("ones_6400", {16'b0, od[1]}, 32'd6400);

    // Positive and negative saturation, with and without ReLU.
    fill(16'd32767, 16'd32767, 16'd32767, 16'd32767);
    beat(); idle(9);
    chk("sat_pos", {16'b0, od[1]}, 32'd32767);
    fill(16'd32767, 16'h8000, 16'd32767, 16'h8000);
    beat(); idle(9);
    chk("sat_neg", {16'b0, od[1]}, 32'h8000);
    chk("sat_relu", {16'b0, od[2]}, 32'd0);

    // Floor of -1/256 is -1 LSB.
    fill(16'd0, 16'd0, 16'hFFFF, 16'd1);
    beat(); idle(9);
    chk("floor_m1", {16'b0, od[1]}, 32'hFFFF);

    // Six back-to-back channels, bias 0.5 on the first beat.
    do_reset(1);
    fill(16'd0, 16'd0, 16'd256, 16'd256); bias_v = 16'd128;
    repeat (6) beat();
    idle(9);
    chk("grp_1664", {16'b0, od[0]}, 32'd1664);

    // Same group with idle gaps between beats.
    repeat (6) begin
      beat();
      idle($urandom_range(0, 3));
    end
    idle(9);
    chk("gap_1664", {16'b0, od[0]}, 32'd1664);

    // Three random groups back to back: pulses arrive every 6 cycles.
    for (int b = 0; b < 18; b++) begin rand_window(); beat(); end
    idle(9);

    // Abort a group mid-way; the fresh group must not see its leftovers.
    fill(16'd0, 16'd0, 16'd256, 16'd256); bias_v = 16'd64;
    repeat (3) beat();
    do_reset(1);
    fill(16'd0, 16'd0, 16'd512, 16'd256); bias_v = 16'd0;
    repeat (6) beat();
    idle(9);
    chk("abort_3072", {16'b0, od[0]}, 32'd3072);

    // Random beats, random gaps and occasional resets.
    for (int b = 0; b < 200; b++) begin
      rand_window();
      if ($urandom_range(0, 9) < 2) for (int i = 0; i < N; i++) din[i] = DW'($urandom_range(0, 512));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0); tick();
      end
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
